uc_reset_sequencer: RTL and testbench

Downstream stage of the dual-processor watchdog monitor. It consumes the monitor's per-processor reset requests (`resetUC1`, `resetUC2`) and its `selectedProcessor` choice, and drives the physical active-low reset lines of the two microcontrollers. Each reset is a guaranteed minimum-width pulse, followed by a hold-off window and a lockout after repeated failures. Output-path switchover between processors is glitch-free, with a blanking interval.

---
 rtl/uc_reset_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_uc_reset_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uc_reset_sequencer.sv
// uc_reset_sequencer
//   Turns the watchdog monitor's reset requests into minimum-width active-low
//   reset pulses for two microcontrollers. After each pulse a channel ignores
//   requests for a hold-off window. A channel locks out once its failure count
//   reaches MAX_RESETS. Switching between processors blanks outputEnable for a
//   fixed number of cycles.
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   asynchronous active-low system reset
//   resetUC1/resetUC2  in   reset requests, rising edge triggers a pulse
//   selectedProcessor  in   0 = UC1, 1 = UC2
//   nrstUC1/nrstUC2    out  active-low reset pins
//   activeUC           out  selection applied after blanking
//   outputEnable       out  active processor usable (not blanking, out of reset, unlocked)
//   failCount1/2       out  saturating count of request-triggered pulses
//   lockUC1/lockUC2    out  channel permanently held in reset
module uc_reset_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned HOLD_CYCLES  = 32,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned MAX_RESETS   = 7,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             resetUC1,
    input  logic             resetUC2,
    input  logic             selectedProcessor,
    output logic             nrstUC1,
    output logic             nrstUC2,
    output logic             activeUC,
    output logic             outputEnable,
    output logic [CNT_W-1:0] failCount1,
    output logic [CNT_W-1:0] failCount2,
    output logic             lockUC1,
    output logic             lockUC2
);

    localparam int unsigned PULSE_MAX = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
    localparam int unsigned PW        = $clog2(PULSE_MAX + 1);
    localparam int unsigned BW        = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {
        StAssert,
        StHoldoff,
        StIdle,
        StLocked
    } ch_state_e;

    ch_state_e        state_q [2];
    ch_state_e        state_d [2];
    logic [PW-1:0]    pcnt_q  [2];
    logic [PW-1:0]    pcnt_d  [2];
    logic [CNT_W-1:0] fcnt_q  [2];
    logic [CNT_W-1:0] fcnt_d  [2];
    logic [1:0]       req;
    logic [1:0]       req_dly_q;
    logic [1:0]       nrst_q, nrst_d;
    logic [1:0]       lock_q, lock_d;

    logic             blank_q, blank_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             active_q, active_d;
    logic             oe_q, oe_d;

    assign req = {resetUC2, resetUC1};

    // Per-channel next state. Counters restart at zero on every state entry.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            pcnt_d[i]  = pcnt_q[i];
            fcnt_d[i]  = fcnt_q[i];
            nrst_d[i]  = nrst_q[i];
            lock_d[i]  = lock_q[i];
            unique case (state_q[i])
                StAssert: begin
                    if (pcnt_q[i] == PW'(RST_CYCLES - 1)) begin
                        pcnt_d[i] = '0;
                        if (fcnt_q[i] == CNT_W'(MAX_RESETS)) begin
                            state_d[i] = StLocked;
                            lock_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = StHoldoff;
                            nrst_d[i]  = 1'b1;
                        end
                    end else begin
                        pcnt_d[i] = pcnt_q[i] + 1'b1;
                    end
                end
                StHoldoff: begin
                    if (pcnt_q[i] == PW'(HOLD_CYCLES - 1)) begin
                        pcnt_d[i]  = '0;
                        state_d[i] = StIdle;
                    end else begin
                        pcnt_d[i] = pcnt_q[i] + 1'b1;
                    end
                end
                StIdle: begin
                    // Only a fresh 0->1 transition seen while idle starts a pulse.
                    if (req[i] && !req_dly_q[i]) begin
                        state_d[i] = StAssert;
                        pcnt_d[i]  = '0;
                        nrst_d[i]  = 1'b0;
                        if (fcnt_q[i] != '1) begin
                            fcnt_d[i] = fcnt_q[i] + 1'b1;
                        end
                    end
                end
                StLocked: begin
                    nrst_d[i] = 1'b0;
                end
                default: begin
                    state_d[i] = StAssert;
                    pcnt_d[i]  = '0;
                    nrst_d[i]  = 1'b0;
                end
            endcase
        end
    end

    // Selection path. A toggle back during blanking still lets blanking run out;
    // activeUC then simply reloads the value it already holds.
    always_comb begin
        blank_d  = blank_q;
        bcnt_d   = bcnt_q;
        active_d = active_q;
        if (blank_q) begin
            if (bcnt_q == BW'(BLANK_CYCLES - 1)) begin
                blank_d  = 1'b0;
                bcnt_d   = '0;
                active_d = selectedProcessor;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end else if (selectedProcessor != active_q) begin
            blank_d = 1'b1;
            bcnt_d  = '0;
        end
        // Built from next-state values so enable tracks nrst/activeUC on the same edge.
        oe_d = !blank_d && nrst_d[active_d] && !lock_d[active_d];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StAssert;
                pcnt_q[i]  <= '0;
                fcnt_q[i]  <= '0;
            end
            req_dly_q <= '0;
            nrst_q    <= '0;
            lock_q    <= '0;
            blank_q   <= 1'b0;
            bcnt_q    <= '0;
            active_q  <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                pcnt_q[i]  <= pcnt_d[i];
                fcnt_q[i]  <= fcnt_d[i];
            end
            req_dly_q <= req;
            nrst_q    <= nrst_d;
            lock_q    <= lock_d;
            blank_q   <= blank_d;
            bcnt_q    <= bcnt_d;
            active_q  <= active_d;
            oe_q      <= oe_d;
        end
    end

    assign nrstUC1      = nrst_q[0];
    assign nrstUC2      = nrst_q[1];
    assign lockUC1      = lock_q[0];
    assign lockUC2      = lock_q[1];
    assign failCount1   = fcnt_q[0];
    assign failCount2   = fcnt_q[1];
    assign activeUC     = active_q;
    assign outputEnable = oe_q;

endmodule

// File: tb/tb_uc_reset_sequencer.sv
// Directed bench for uc_reset_sequencer with default parameters
// (16-cycle pulse, 32-cycle hold-off, 4-cycle blanking, lockout at 7).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uc_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       resetUC1 = 1'b0;
    logic       resetUC2 = 1'b0;
    logic       selectedProcessor = 1'b0;
    logic       nrstUC1, nrstUC2, activeUC, outputEnable, lockUC1, lockUC2;
    logic [2:0] failCount1, failCount2;

    int n_checks = 0;
    int n_errors = 0;

    uc_reset_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .resetUC1         (resetUC1),
        .resetUC2         (resetUC2),
        .selectedProcessor(selectedProcessor),
        .nrstUC1          (nrstUC1),
        .nrstUC2          (nrstUC2),
        .activeUC         (activeUC),
        .outputEnable     (outputEnable),
        .failCount1       (failCount1),
        .failCount2       (failCount2),
        .lockUC1          (lockUC1),
        .lockUC2          (lockUC2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request pulse on the selected channels; returns just after the accepting edge.
    task automatic request(input logic r1, input logic r2);
        resetUC1 = r1;
        resetUC2 = r2;
        @(negedge clk);
        resetUC1 = 1'b0;
        resetUC2 = 1'b0;
    endtask

    // Releases reset and checks the 16-cycle power-on pulse on both channels.
    task automatic power_on(input string tag);
        reset = 1'b1;
        cycles(15);
        check({tag, "_nrst1_edge15"}, int'(nrstUC1), 0);
        check({tag, "_oe_edge15"}, int'(outputEnable), 0);
        cycles(1);
        check({tag, "_nrst1_edge16"}, int'(nrstUC1), 1);
        check({tag, "_nrst2_edge16"}, int'(nrstUC2), 1);
        check({tag, "_oe_edge16"}, int'(outputEnable), 1);
        check({tag, "_fail1"}, int'(failCount1), 0);
        check({tag, "_fail2"}, int'(failCount2), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  cnt;
        bit  bad;

        // Power-on
        cycles(5);
        check("rst_nrst1", int'(nrstUC1), 0);
        check("rst_nrst2", int'(nrstUC2), 0);
        check("rst_oe", int'(outputEnable), 0);
        check("rst_active", int'(activeUC), 0);
        check("rst_lock2", int'(lockUC2), 0);
        power_on("boot");
        cycles(40);

        // Single request on UC1
        request(1'b1, 1'b0);
        check("single_nrst1_low", int'(nrstUC1), 0);
        check("single_fail1", int'(failCount1), 1);
        cnt = 0;
        bad = 1'b0;
        while (nrstUC1 == 1'b0 && cnt < 100) begin
            if (outputEnable || !nrstUC2) bad = 1'b1;
            cnt++;
            @(negedge clk);
        end
        check("single_width", cnt, 16);
        check("single_oe_low_uc2_high", int'(bad), 0);

        // Edge during hold-off is dropped
        cycles(10);
        request(1'b1, 1'b0);
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (!nrstUC1) bad = 1'b1;
            @(negedge clk);
        end
        check("holdoff_no_pulse", int'(bad), 0);
        check("holdoff_fail1", int'(failCount1), 1);
        request(1'b1, 1'b0);
        check("holdoff_fresh_low", int'(nrstUC1), 0);
        check("holdoff_fresh_fail1", int'(failCount1), 2);
        cycles(50);

        // Switchover 0 -> 1 with both channels idle
        selectedProcessor = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sw_oe_blank", int'(outputEnable), 0);
        end
        check("sw_active_before", int'(activeUC), 0);
        @(negedge clk);
        check("sw_active_after", int'(activeUC), 1);
        check("sw_oe_after", int'(outputEnable), 1);
        selectedProcessor = 1'b0;
        cycles(6);
        check("sw_back_active", int'(activeUC), 0);
        check("sw_back_oe", int'(outputEnable), 1);

        // Simultaneous requests
        request(1'b1, 1'b1);
        cnt = 0;
        bad = 1'b0;
        while ((!nrstUC1 || !nrstUC2) && cnt < 100) begin
            if (nrstUC1 != nrstUC2) bad = 1'b1;
            cnt++;
            @(negedge clk);
        end
        check("simul_width", cnt, 16);
        check("simul_aligned", int'(bad), 0);
        check("simul_fail1", int'(failCount1), 3);
        check("simul_fail2", int'(failCount2), 1);
        cycles(50);

        // Lockout on UC2
        for (int i = 0; i < 5; i++) begin
            request(1'b0, 1'b1);
            check("lock_count", int'(failCount2), i + 2);
            cycles(50);
        end
        request(1'b0, 1'b1);
        check("lock_count7", int'(failCount2), 7);
        check("lock_not_yet", int'(lockUC2), 0);
        cycles(15);
        check("lock_edge15", int'(lockUC2), 0);
        cycles(1);
        check("lock_edge16", int'(lockUC2), 1);
        check("lock_nrst2_low", int'(nrstUC2), 0);
        cycles(40);
        check("lock_nrst2_stays", int'(nrstUC2), 0);
        request(1'b0, 1'b1);
        cycles(2);
        check("lock_8th_count", int'(failCount2), 7);
        check("lock_8th_nrst2", int'(nrstUC2), 0);
        check("lock_uc1_oe", int'(outputEnable), 1);
        check("lock_uc1_free", int'(lockUC1), 0);

        // Switch onto locked UC2
        selectedProcessor = 1'b1;
        cycles(5);
        check("swlock_active", int'(activeUC), 1);
        check("swlock_oe", int'(outputEnable), 0);
        selectedProcessor = 1'b0;
        cycles(6);
        check("swlock_back_oe", int'(outputEnable), 1);

        // Abort mid-pulse
        request(1'b1, 1'b0);
        check("abort_fail1_pre", int'(failCount1), 4);
        cycles(5);
        reset = 1'b0;
        #1;
        check("abort_fail1", int'(failCount1), 0);
        check("abort_fail2", int'(failCount2), 0);
        check("abort_lock2", int'(lockUC2), 0);
        check("abort_nrst2", int'(nrstUC2), 0);
        check("abort_oe", int'(outputEnable), 0);
        cycles(3);
        power_on("reboot");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
